// File: rtl/vec_replay_sched.sv
// -----------------------------------------------------------------------------
// vec_replay_sched
//
// Read-side scheduler for a vector FIFO that supports replay. A producer writes
// vectors in BytesPerWrite chunks (accepted in any state, so vectors can be
// prefetched before a job starts). A job reads num_vectors vectors, each one
// num_repeats times, in BytesPerRead beats. Between passes of the same vector
// the FIFO read pointer is rewound with a one-cycle fifo_wrap_rd. A vector is
// released from storage only after the final beat of its final pass.
//
// Ports
//   clk_in        rising-edge clock
//   rst_in        synchronous active-high reset (also resets the FIFO)
//   start         begin a job (sampled only when idle)
//   num_vectors   vectors in the job, latched on an accepted start
//   num_repeats   passes per vector, latched on an accepted start (0 -> 1)
//   abort         cancel the job from any state, flush the FIFO
//   in_valid      producer offers one write of BytesPerWrite bytes
//   in_ready      storage has room for another vector
//   fifo_wr_en    FIFO write enable (in_valid & in_ready)
//   out_ready     consumer accepts a read beat
//   fifo_rd_en    FIFO read enable; also the valid qualifier of FIFO rd_data
//   fifo_wrap_rd  FIFO rewind to the start of the current vector
//   fifo_flush    one-cycle FIFO flush on abort
//   last_beat     marks the final beat of a pass (with fifo_rd_en)
//   busy          controller is not idle
//   done          one-cycle pulse at job completion
//
// Depth*VecElements is expected to be a power of two so the FIFO pointers wrap
// naturally; BytesPerWrite and BytesPerRead must divide VecElements.
// -----------------------------------------------------------------------------
module vec_replay_sched #(
    parameter int VecElements   = 8,
    parameter int BytesPerWrite = 4,
    parameter int BytesPerRead  = 2,
    parameter int Depth         = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start,
    input  logic [15:0] num_vectors,
    input  logic [15:0] num_repeats,
    input  logic        abort,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        fifo_wr_en,
    input  logic        out_ready,
    output logic        fifo_rd_en,
    output logic        fifo_wrap_rd,
    output logic        fifo_flush,
    output logic        last_beat,
    output logic        busy,
    output logic        done
);

    localparam int R  = VecElements / BytesPerRead;   // beats per pass
    localparam int W  = VecElements / BytesPerWrite;  // writes per vector
    localparam int BW = (R > 1) ? $clog2(R) : 1;
    localparam int WW = (W > 1) ? $clog2(W) : 1;
    localparam int CW = $clog2(Depth + 1);

    localparam logic [BW-1:0] BEAT_LAST = BW'(R - 1);
    localparam logic [WW-1:0] WR_LAST   = WW'(W - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(Depth);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_WRAP,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [15:0]   pass_q, pass_d;
    logic [15:0]   vec_idx_q, vec_idx_d;
    logic [15:0]   nvec_q, nvec_d;
    logic [15:0]   reps_q, reps_d;
    logic [WW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] vec_count_q, vec_count_d;

    logic vec_avail;
    logic more_passes;
    logic vec_written;
    logic vec_consumed;

    // in_ready is forced high during reset: the FIFO is held in reset too, so
    // the write is harmless and the producer never sees a stale full flag.
    assign in_ready   = rst_in | (vec_count_q < DEPTH_C);
    assign fifo_wr_en = in_valid & in_ready;

    assign vec_avail    = (vec_count_q != '0);
    // reps_q is at least 1 whenever a beat can issue, so the subtraction
    // cannot underflow where this is used.
    assign more_passes  = (pass_q < (reps_q - 16'd1));
    assign vec_written  = fifo_wr_en & (wr_cnt_q == WR_LAST);
    assign vec_consumed = last_beat & ~more_passes;

    // -------------------------------------------------------------------------
    // State and counter registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            pass_q      <= '0;
            vec_idx_q   <= '0;
            nvec_q      <= '0;
            reps_q      <= '0;
            wr_cnt_q    <= '0;
            vec_count_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            pass_q      <= pass_d;
            vec_idx_q   <= vec_idx_d;
            nvec_q      <= nvec_d;
            reps_q      <= reps_d;
            wr_cnt_q    <= wr_cnt_d;
            vec_count_q <= vec_count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and job counters
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        pass_d    = pass_q;
        vec_idx_d = vec_idx_q;
        nvec_d    = nvec_q;
        reps_d    = reps_q;

        if (abort) begin
            state_d   = S_IDLE;
            beat_d    = '0;
            pass_d    = '0;
            vec_idx_d = '0;
            nvec_d    = '0;
            reps_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        nvec_d    = num_vectors;
                        reps_d    = (num_repeats == 16'd0) ? 16'd1 : num_repeats;
                        beat_d    = '0;
                        pass_d    = '0;
                        vec_idx_d = '0;
                        state_d   = (num_vectors == 16'd0) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (vec_avail) begin
                        state_d = S_READ;
                    end
                end
                S_READ: begin
                    if (fifo_rd_en) begin
                        if (beat_q == BEAT_LAST) begin
                            beat_d = '0;
                            if (more_passes) begin
                                pass_d  = pass_q + 16'd1;
                                state_d = S_WRAP;
                            end else begin
                                pass_d    = '0;
                                vec_idx_d = vec_idx_q + 16'd1;
                                state_d   = ((vec_idx_q + 16'd1) == nvec_q) ? S_DONE : S_WAIT;
                            end
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
                S_WRAP: begin
                    beat_d  = '0;
                    state_d = S_READ;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Write-side accounting: partial-vector write count and stored vectors
    // -------------------------------------------------------------------------
    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        vec_count_d = vec_count_q;

        if (abort) begin
            wr_cnt_d    = '0;
            vec_count_d = '0;
        end else begin
            if (fifo_wr_en) begin
                wr_cnt_d = (wr_cnt_q == WR_LAST) ? '0 : wr_cnt_q + 1'b1;
            end
            // A vector arriving in the same cycle one is released nets to zero.
            case ({vec_written, vec_consumed})
                2'b10:   vec_count_d = vec_count_q + 1'b1;
                2'b01:   vec_count_d = vec_count_q - 1'b1;
                default: vec_count_d = vec_count_q;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: abort and reset suppress every read-side strobe that cycle
    // -------------------------------------------------------------------------
    always_comb begin
        fifo_rd_en   = 1'b0;
        fifo_wrap_rd = 1'b0;
        last_beat    = 1'b0;
        done         = 1'b0;
        busy         = 1'b0;
        fifo_flush   = 1'b0;

        if (!rst_in && !abort) begin
            case (state_q)
                S_READ: begin
                    fifo_rd_en = out_ready & vec_avail;
                    last_beat  = out_ready & vec_avail & (beat_q == BEAT_LAST);
                end
                S_WRAP:  fifo_wrap_rd = 1'b1;
                S_DONE:  done = 1'b1;
                default: ;
            endcase
        end

        busy       = !rst_in && (state_q != S_IDLE);
        fifo_flush = !rst_in && abort;
    end

endmodule

// File: tb/tb_vec_replay_sched.sv
// -----------------------------------------------------------------------------
// Bench for vec_replay_sched: directed scenarios with cycle-exact expectations,
// then randomized jobs, producer and consumer traffic, with every cycle checked
// against a job-level model (stored-vector count, job cursor of
// vector/pass/beat, pending wrap/done events).
// -----------------------------------------------------------------------------
module tb_vec_replay_sched;

    localparam int VE  = 8;
    localparam int BPW = 4;
    localparam int BPR = 2;
    localparam int DEP = 4;
    localparam int R   = VE / BPR;
    localparam int W   = VE / BPW;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        start;
    logic [15:0] num_vectors;
    logic [15:0] num_repeats;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic        fifo_wr_en;
    logic        out_ready;
    logic        fifo_rd_en;
    logic        fifo_wrap_rd;
    logic        fifo_flush;
    logic        last_beat;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    vec_replay_sched #(
        .VecElements  (VE),
        .BytesPerWrite(BPW),
        .BytesPerRead (BPR),
        .Depth        (DEP)
    ) dut (
        .clk_in      (clk),
        .rst_in      (rst_in),
        .start       (start),
        .num_vectors (num_vectors),
        .num_repeats (num_repeats),
        .abort       (abort),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .fifo_wr_en  (fifo_wr_en),
        .out_ready   (out_ready),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_wrap_rd(fifo_wrap_rd),
        .fifo_flush  (fifo_flush),
        .last_beat   (last_beat),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- job-level reference model ----------------
    bit m_busy, m_reading, m_waiting, m_wrap_now, m_done_now;
    int m_stored, m_part, m_beat, m_pass, m_vec, m_nv, m_reps;
    int n_wr, n_beats, n_wraps, n_dones;

    task automatic model_clear();
        m_busy = 0; m_reading = 0; m_waiting = 0; m_wrap_now = 0; m_done_now = 0;
        m_stored = 0; m_part = 0; m_beat = 0; m_pass = 0; m_vec = 0; m_nv = 0; m_reps = 0;
    endtask

    initial begin
        bit exp_rdy, exp_rd, nw, nd;
        int inc, dec;
        model_clear();
        n_wr = 0; n_beats = 0; n_wraps = 0; n_dones = 0;
        forever begin
            @(negedge clk);
            if (rst_in) begin
                chk("rst_in_ready", 64'(in_ready), 64'd1);
                chk("rst_wr_en", 64'(fifo_wr_en), 64'(in_valid));
                chk("rst_quiet", 64'({fifo_rd_en, fifo_wrap_rd, fifo_flush, last_beat, busy, done}), 64'd0);
                model_clear();
            end else begin
                exp_rdy = (m_stored < DEP);
                exp_rd  = m_reading && out_ready && !abort;
                chk("in_ready", 64'(in_ready), 64'(exp_rdy));
                chk("wr_en", 64'(fifo_wr_en), 64'(in_valid && exp_rdy));
                chk("rd_en", 64'(fifo_rd_en), 64'(exp_rd));
                chk("last_beat", 64'(last_beat), 64'(exp_rd && (m_beat == R - 1)));
                chk("wrap_rd", 64'(fifo_wrap_rd), 64'(m_wrap_now && !abort));
                chk("done", 64'(done), 64'(m_done_now && !abort));
                chk("busy", 64'(busy), 64'(m_busy));
                chk("flush", 64'(fifo_flush), 64'(abort));
                chk("rd_wrap_excl", 64'(fifo_rd_en & fifo_wrap_rd), 64'd0);

                if (fifo_wr_en)   n_wr++;
                if (fifo_rd_en)   n_beats++;
                if (fifo_wrap_rd) n_wraps++;
                if (done)         n_dones++;

                if (abort) begin
                    model_clear();
                end else begin
                    inc = 0; dec = 0; nw = 0; nd = 0;
                    if (in_valid && exp_rdy) begin
                        m_part++;
                        if (m_part == W) begin
                            m_part = 0;
                            inc = 1;
                        end
                    end
                    if (m_done_now) begin
                        m_busy = 0;
                    end else if (!m_busy) begin
                        if (start) begin
                            m_busy = 1;
                            m_nv = int'(num_vectors);
                            m_reps = (num_repeats == 16'd0) ? 1 : int'(num_repeats);
                            m_beat = 0; m_pass = 0; m_vec = 0;
                            m_reading = 0;
                            m_waiting = (num_vectors != 16'd0);
                            nd = (num_vectors == 16'd0);
                        end
                    end else if (m_wrap_now) begin
                        m_reading = 1;
                    end else if (m_waiting) begin
                        if (m_stored > 0) begin
                            m_waiting = 0;
                            m_reading = 1;
                        end
                    end else if (exp_rd) begin
                        m_beat++;
                        if (m_beat == R) begin
                            m_beat = 0;
                            m_reading = 0;
                            if (m_pass < m_reps - 1) begin
                                m_pass++;
                                nw = 1;
                            end else begin
                                m_pass = 0;
                                m_vec++;
                                dec = 1;
                                if (m_vec == m_nv) nd = 1;
                                else m_waiting = 1;
                            end
                        end
                    end
                    m_stored   = m_stored + inc - dec;
                    m_wrap_now = nw;
                    m_done_now = nd;
                end
            end
        end
    end

    // ---------------- random producer/consumer traffic ----------------
    bit rand_en = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_en) begin
                in_valid  = ($urandom_range(0, 9) < 6);
                out_ready = ($urandom_range(0, 9) < 7);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_vecs(input int n);
        in_valid = 1'b1;
        repeat (n * W) tick();
        in_valid = 1'b0;
    endtask

    // Starts a job and records one bit per cycle, cycle 0 being the start cycle.
    logic [63:0] lg_rd, lg_last, lg_wrap, lg_done, lg_rdy, lg_busy, lg_flush, lg_ordy;

    task automatic run_log(input int ncyc, input logic [15:0] nv, input logic [15:0] nr,
                           input logic [63:0] iv_mask, input bit toggle, input int abort_at);
        lg_rd = '0; lg_last = '0; lg_wrap = '0; lg_done = '0;
        lg_rdy = '0; lg_busy = '0; lg_flush = '0; lg_ordy = '0;
        num_vectors = nv;
        num_repeats = nr;
        start       = 1'b1;
        in_valid    = iv_mask[0];
        abort       = (abort_at == 0);
        out_ready   = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            lg_rd[i]    = fifo_rd_en;
            lg_last[i]  = last_beat;
            lg_wrap[i]  = fifo_wrap_rd;
            lg_done[i]  = done;
            lg_rdy[i]   = in_ready;
            lg_busy[i]  = busy;
            lg_flush[i] = fifo_flush;
            lg_ordy[i]  = out_ready;
            @(posedge clk);
            #1;
            start    = 1'b0;
            in_valid = iv_mask[i + 1];
            abort    = (abort_at == i + 1);
            if (toggle) out_ready = ~out_ready;
        end
        in_valid  = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int w0, k, to, abd;
        bit ab;

        rst_in = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        num_vectors = '0; num_repeats = '0;
        repeat (3) tick();
        rst_in = 1'b0; in_valid = 1'b0;
        tick();

        // single vector, single pass
        write_vecs(1);
        run_log(10, 16'd1, 16'd1, 64'd0, 1'b0, -1);
        chk("t1_rd", lg_rd, 64'h3C);
        chk("t1_last", lg_last, 64'h20);
        chk("t1_done", lg_done, 64'h40);
        chk("t1_busy", lg_busy, 64'h7E);
        chk("t1_wrap", lg_wrap, 64'h0);

        // replay of one vector, three passes
        write_vecs(1);
        run_log(20, 16'd1, 16'd3, 64'd0, 1'b0, -1);
        chk("t2_rd", lg_rd, 64'hF7BC);
        chk("t2_wrap", lg_wrap, 64'h840);
        chk("t2_last", lg_last, 64'h8420);
        chk("t2_done", lg_done, 64'h10000);

        // fill to Depth, then drain with consumer backpressure
        w0 = n_wr;
        in_valid = 1'b1;
        repeat (10) tick();
        in_valid = 1'b0;
        chk("t3_full_writes", 64'(n_wr - w0), 64'd8);
        chk("t3_full_in_ready", 64'(in_ready), 64'd0);
        run_log(60, 16'd4, 16'd1, 64'd0, 1'b1, -1);
        chk("t3_no_beat_when_stalled", lg_rd & ~lg_ordy, 64'd0);
        chk("t3_beats", 64'($countones(lg_rd)), 64'd16);
        chk("t3_dones", 64'($countones(lg_done)), 64'd1);
        k = 63;
        for (int i = 62; i >= 0; i--) if (lg_last[i]) k = i;
        chk("t3_first_last", 64'(k), 64'd8);
        chk("t3_rdy_at_last", 64'(lg_rdy[k]), 64'd0);
        chk("t3_rdy_after_last", 64'(lg_rdy[k + 1]), 64'd1);

        // vector write completes on the cycle of the final last beat
        write_vecs(1);
        run_log(10, 16'd1, 16'd1, 64'h30, 1'b0, -1);
        chk("t4_last", lg_last, 64'h20);
        run_log(10, 16'd1, 16'd1, 64'd0, 1'b0, -1);
        chk("t4_kept_rd", lg_rd, 64'h3C);
        chk("t4_kept_done", lg_done, 64'h40);

        // edge jobs
        run_log(6, 16'd0, 16'd1, 64'd0, 1'b0, -1);
        chk("t5_nv0_done", lg_done, 64'h2);
        chk("t5_nv0_rd", lg_rd, 64'h0);
        chk("t5_nv0_busy", lg_busy, 64'h2);
        write_vecs(1);
        run_log(10, 16'd1, 16'd0, 64'd0, 1'b0, -1);
        chk("t5_rep0_rd", lg_rd, 64'h3C);
        chk("t5_rep0_wrap", lg_wrap, 64'h0);
        chk("t5_rep0_done", lg_done, 64'h40);

        // abort during the first wrap of a 2x2 job
        write_vecs(2);
        run_log(12, 16'd2, 16'd2, 64'd0, 1'b0, 6);
        chk("t6_flush", lg_flush, 64'h40);
        chk("t6_done", lg_done, 64'h0);
        chk("t6_busy", lg_busy, 64'h7E);
        chk("t6_rd", lg_rd, 64'h3C);
        w0 = n_wr;
        in_valid = 1'b1;
        repeat (10) tick();
        in_valid = 1'b0;
        chk("t6_refill_writes", 64'(n_wr - w0), 64'd8);
        run_log(30, 16'd2, 16'd2, 64'd0, 1'b0, -1);
        chk("t6_fresh_beats", 64'($countones(lg_rd)), 64'd16);
        chk("t6_fresh_wrap", lg_wrap, 64'h10040);
        chk("t6_fresh_done", lg_done, 64'h200000);

        // randomized jobs, traffic, ignored starts and aborts
        rand_en = 1;
        for (int j = 0; j < 40; j++) begin
            repeat ($urandom_range(0, 5)) tick();
            num_vectors = 16'($urandom_range(0, 5));
            num_repeats = 16'($urandom_range(0, 3));
            start = 1'b1;
            tick();
            start = 1'b0;
            ab  = ($urandom_range(0, 7) == 0);
            abd = $urandom_range(1, 30);
            to  = 0;
            while (m_busy && to < 3000) begin
                abort = ab && (to == abd);
                start = (to == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
                tick();
                to++;
            end
            abort = 1'b0;
            start = 1'b0;
            chk("job_timeout", 64'(to >= 3000), 64'd0);
        end
        rand_en = 0;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
